dense_reuse_layer: RTL and testbench
====================================

# dense_reuse_layer

Time-multiplexed fully-connected layer with optional ReLU. It sits directly downstream of the stride-2 convolution stage (`ramConnector`) inside `encoder`. It consumes one frame of 128 signed Q5.10 activations and produces the 16 encoder outputs. It replaces a fully parallel dense layer by sharing `LANES` multiply-accumulate units across all output neurons.

## Interface
Parameters:
- `WIDTH`, 16: data, weight and bias word width, signed.
- `FRAC`, 10: fractional bits of every word (Q5.10).
- `N_IN`, 128: input activations per frame.
- `N_OUT`, 16: output neurons. Must be a multiple of `LANES`.
- `LANES`, 4: parallel MAC lanes. `G = N_OUT/LANES` neuron groups.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `inputData` holds a complete frame.
- `in_ready`, out, 1: block is idle and can accept a frame.
- `inputData`, in, `WIDTH` × [`N_IN`-1:0]: signed activations.
- `biases`, in, `WIDTH` × [`N_OUT`-1:0]: signed biases. Must be held stable while busy.
- `w_addr`, out, $clog2(G·N_IN): weight ROM address, equal to g·N_IN+i.
- `w_data`, in, `WIDTH` × [`LANES`-1:0]: combinational (same-cycle) ROM data. `w_data[l]` = W[g·LANES+l][i].
- `out_valid`, out, 1: one-cycle pulse when a new `outputData` frame is available.
- `outputData`, out, `WIDTH` × [`N_OUT`-1:0]: signed results. Held until the next frame completes.

## Operation
- States: IDLE, MAC, FINISH, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `inputData` into the frame register, set g=0 and i=0, clear all lane accumulators, go to MAC.
- **MAC**
  - Every cycle, for each lane l: acc[l] += frame[i] × w_data[l].
  - Accumulator width is 2·`WIDTH`+$clog2(`N_IN`) = 39 bits, so it cannot overflow.
  - i increments each cycle. After i=`N_IN`-1, go to FINISH.
- **FINISH** (1 cycle), per lane:
  - r = (acc + (bias <<< `FRAC`)) >>> `FRAC`. The shift is arithmetic (truncation toward −∞).
  - Saturate r to [−32768, 32767].
  - Apply ReLU (see Configuration).
  - Write the result into `outputData[g·LANES+l]`.
  - Clear the accumulators, set i=0.
  - If g<G−1: g++ and go to MAC. Otherwise go to DONE.
- **DONE** (1 cycle): `out_valid`=1, then go to IDLE.
- `outputData` updates group by group during FINISH cycles. Consumers sample it only on `out_valid`.
- `in_valid` while `in_ready`=0 is ignored. No frame is queued.
- `w_addr` is driven as g·N_IN+i in MAC and as 0 in all other states.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, all `outputData`=0, `w_addr`=0.
  - Accumulators, counters and the frame register are 0. State is IDLE.
- Reset is asserted asynchronously. Deassertion is synchronous to `clk` (synchronised externally).
- Reset mid-operation aborts the frame: no `out_valid`, and `outputData` is cleared to 0.
- Accept edge = cycle 0. MAC occupies `N_IN` cycles per group and FINISH 1 cycle, so each group takes `N_IN`+1 cycles.
- `out_valid` is high in cycle G·(`N_IN`+1)+1. With defaults this is cycle 517.
- `in_ready` returns to 1 in the cycle after `out_valid`. The earliest next accept is at cycle 518, giving a throughput of one frame per 518 cycles.
- The multiply-add is registered in a single stage. No pipeline bubbles exist between groups other than FINISH.

## Configuration
- Macro: `DENSE_RELU_EN`.
- Defined: negative saturated results are written as 0. This merges the following reluLayer into this block.
- Undefined: the saturated signed result is written unchanged.

## Structure
- Shared package `dense_pkg`:
  - `typedef logic signed [WIDTH-1:0] word_t`.
  - Accumulator typedef `acc_t` (39-bit signed).
  - State enum `dense_state_t`.
  - Defaults for `WIDTH`, `FRAC`, `N_IN`, `N_OUT`.
- One sub-module, `dense_mac_lane`:
  - Accumulator register with clear and enable.
  - Multiply-add.
  - Bias align, shift, saturation and ReLU in FINISH.
  - Instantiated `LANES` times.
- The FSM, counters and frame register live in `dense_reuse_layer`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles → `in_ready`=1, `out_valid`=0, all `outputData`=0.
- **Nominal:** all inputs 1024 (1.0), all weights 8, all biases 512 → `out_valid` at cycle 517, and all 16 outputs = 1536.
- **ReLU:** weights −8, bias 0 → expected result −1024.
  - With `DENSE_RELU_EN`: outputs 0.
  - Without it: outputs −1024 (0xFC00).
- **Saturation:** inputs 1024, weights 1024, bias 0 → raw result 131072, outputs clamp to 32767.
  - Same with weights −1024 and `DENSE_RELU_EN` undefined → outputs clamp to −32768.
- **Busy and back-to-back:** hold `in_valid`=1 continuously with changing data → the frame at cycle 0 is accepted, data offered during cycles 1–517 is ignored, and the next accept is at cycle 518. `w_addr` sequence checked: 0..511, 0 outside MAC.
- **Mid-frame reset:** pull `reset` low at cycle 200 → outputs are 0 immediately and no `out_valid` occurs. A fresh nominal frame then yields 1536 at accept+517.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types and default sizes for the time-multiplexed dense layer.
package dense_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 10;
  localparam int DEF_N_IN  = 128;
  localparam int DEF_N_OUT = 16;
  localparam int DEF_LANES = 4;
  localparam int ACC_W     = 2 * DEF_WIDTH + $clog2(DEF_N_IN);

  typedef logic signed [DEF_WIDTH-1:0] word_t;
  typedef logic signed [ACC_W-1:0]     acc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } dense_state_t;

endpackage

// File: rtl/dense_mac_lane.sv
// One shared MAC lane: accumulator with clear/enable, plus bias align, floor shift,
// saturation and optional ReLU (enabled by DENSE_RELU_EN) on the finished sum.
module dense_mac_lane
  import dense_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int N_IN  = DEF_N_IN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] w,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] res
);

  localparam int AW = 2 * WIDTH + $clog2(N_IN);

  // One bit of headroom so the bias add cannot wrap the full-scale accumulator.
  localparam logic signed [AW:0] SAT_HI = {{(AW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] SAT_LO = ~SAT_HI;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      acc_p1;
  logic signed [AW:0]        bias_al;
  logic signed [AW:0]        sum;
  logic signed [AW:0]        shifted;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW:0] v);
    if (v > SAT_HI)      return SAT_HI[WIDTH-1:0];
    else if (v < SAT_LO) return SAT_LO[WIDTH-1:0];
    else                 return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] x);
`ifdef DENSE_RELU_EN
    return x[WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign prod = a * w;

  // Stage p1: accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc_p1 <= '0;
    else if (clr) acc_p1 <= '0;
    else if (en)  acc_p1 <= acc_p1 + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  end

  assign bias_al = {{(AW+1-WIDTH-FRAC){bias[WIDTH-1]}}, bias, {FRAC{1'b0}}};
  assign sum     = {acc_p1[AW-1], acc_p1} + bias_al;
  assign shifted = sum >>> FRAC;
  assign res     = relu(sat(shifted));

endmodule

// File: rtl/dense_reuse_layer.sv
// Fully-connected layer sharing LANES MAC units across N_OUT neurons, one group at a time.
// Optional ReLU on the outputs is selected with DENSE_RELU_EN (see dense_mac_lane).
module dense_reuse_layer
  import dense_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int LANES = DEF_LANES
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [WIDTH-1:0]                inputData [N_IN-1:0],
  input  logic signed [WIDTH-1:0]                biases [N_OUT-1:0],
  output logic [$clog2(N_OUT/LANES*N_IN)-1:0]    w_addr,
  input  logic signed [WIDTH-1:0]                w_data [LANES-1:0],
  output logic                                   out_valid,
  output logic signed [WIDTH-1:0]                outputData [N_OUT-1:0]
);

  localparam int G  = N_OUT / LANES;
  localparam int AW = $clog2(G * N_IN);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  dense_state_t state, state_nx;
  logic [IW-1:0] i_cnt;
  logic [GW-1:0] g_cnt;
  logic signed [WIDTH-1:0] frame_p0 [N_IN-1:0];
  logic signed [WIDTH-1:0] mac_a;
  logic signed [WIDTH-1:0] lane_bias [LANES-1:0];
  logic signed [WIDTH-1:0] lane_res [LANES-1:0];
  logic acc_clr, acc_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    w_addr    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_clr  = 1'b1;
          state_nx = MAC;
        end
      end
      MAC: begin
        acc_en = 1'b1;
        w_addr = AW'(int'(g_cnt) * N_IN + int'(i_cnt));
        if (i_cnt == I_LAST) state_nx = FINISH;
      end
      FINISH: begin
        acc_clr  = 1'b1;
        state_nx = (g_cnt == G_LAST) ? DONE : MAC;
      end
      default: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
    endcase
  end

  // Constant-index mux keeps the bias select free of wide runtime indexing.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_bias[l] = biases[l];
      for (int gg = 0; gg < G; gg++)
        if (g_cnt == GW'(gg)) lane_bias[l] = biases[gg*LANES+l];
    end
  end

  assign mac_a = frame_p0[i_cnt];

  // Stage p0: frame latch, counters and per-group result write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_cnt <= '0;
      g_cnt <= '0;
      for (int k = 0; k < N_IN; k++)  frame_p0[k]   <= '0;
      for (int k = 0; k < N_OUT; k++) outputData[k] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          frame_p0 <= inputData;
          i_cnt    <= '0;
          g_cnt    <= '0;
        end
        MAC: i_cnt <= i_cnt + 1'b1;
        FINISH: begin
          i_cnt <= '0;
          for (int gg = 0; gg < G; gg++)
            if (g_cnt == GW'(gg))
              for (int l = 0; l < LANES; l++) outputData[gg*LANES+l] <= lane_res[l];
          if (g_cnt != G_LAST) g_cnt <= g_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dense_mac_lane #(.WIDTH(WIDTH), .FRAC(FRAC), .N_IN(N_IN)) u_lane (
      .clk  (clk),
      .reset(reset),
      .clr  (acc_clr),
      .en   (acc_en),
      .a    (mac_a),
      .w    (w_data[l]),
      .bias (lane_bias[l]),
      .res  (lane_res[l])
    );
  end

endmodule

// File: tb/tb_dense_reuse_layer.sv
// Scoreboard bench for dense_reuse_layer: directed frames push expected outputs,
// a negedge monitor pops and compares on out_valid and also tracks w_addr.
module tb_dense_reuse_layer;
  import dense_pkg::*;

  localparam int N_IN  = 128;
  localparam int N_OUT = 16;
  localparam int LANES = 4;
  localparam int LAT   = 517;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  word_t inputData [N_IN-1:0];
  word_t biases [N_OUT-1:0];
  logic [8:0] w_addr;
  word_t w_data [LANES-1:0];
  logic out_valid;
  word_t outputData [N_OUT-1:0];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_accept = -100000;
  int wmode = 0;
  int wval = 0;
  int addr_bad = 0;
  int addr_bad_got = 0;
  int addr_bad_exp = 0;
  logic [255:0] exp_val_q[$];
  int exp_cyc_q[$];
  logic [255:0] exp_next;

  dense_reuse_layer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inputData (inputData),
    .biases    (biases),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .outputData(outputData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight ROM: uniform value, or W[n][i] = n+1 to expose group/lane mapping.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (wmode == 1) w_data[l] = 16'((int'(w_addr) / N_IN) * LANES + l + 1);
      else            w_data[l] = 16'(wval);
    end
  end

  function automatic logic [255:0] uni(input int val);
    logic [255:0] r;
    for (int n = 0; n < N_OUT; n++) r[n*16 +: 16] = val[15:0];
    return r;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [255:0] ev;
    int ec;
    if (reset && out_valid) begin
      checks++;
      if (exp_val_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out_valid: out_valid=1 at cycle %0d, required no frame pending", cyc);
      end else begin
        ev = exp_val_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (cyc != ec) begin
          errors++;
          $display("FAIL out_valid_cycle: got cycle %0d, required %0d", cyc, ec);
        end
        for (int n = 0; n < N_OUT; n++) begin
          checks++;
          if (outputData[n] !== ev[n*16 +: 16]) begin
            errors++;
            $display("FAIL outputData[%0d]: got %0d, required %0d", n, outputData[n],
                     $signed(ev[n*16 +: 16]));
          end
        end
      end
    end
  end

  // Address monitor: g*N_IN+i during MAC, 0 elsewhere; one check per frame.
  always @(negedge clk) begin
    int k, ea;
    k  = cyc - last_accept;
    ea = 0;
    if (k >= 1 && k <= 516 && ((k - 1) % 129) < 128) ea = ((k - 1) / 129) * N_IN + (k - 1) % 129;
    if (reset && int'(w_addr) != ea) begin
      if (addr_bad == 0) begin
        addr_bad_got = int'(w_addr);
        addr_bad_exp = ea;
      end
      addr_bad++;
    end
    if (k == LAT) begin
      checks++;
      if (addr_bad != 0) begin
        errors++;
        $display("FAIL w_addr_seq: %0d bad cycles, first got %0d, required %0d",
                 addr_bad, addr_bad_got, addr_bad_exp);
      end
      addr_bad = 0;
    end
  end

  task automatic setup(input int v, input int w, input int b);
    for (int k = 0; k < N_IN; k++)  inputData[k] = 16'(v);
    for (int n = 0; n < N_OUT; n++) biases[n] = 16'(b);
    wmode = 0;
    wval  = w;
  endtask

  task automatic send();
    int guard = 0;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b, required 1", in_ready);
    end else begin
      in_valid    = 1'b1;
      last_accept = cyc;
      exp_val_q.push_back(exp_next);
      exp_cyc_q.push_back(cyc + LAT);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (exp_val_q.size() != 0 && guard < 1200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_val_q.size() != 0) begin
      errors++;
      $display("FAIL frame_timeout: %0d frames pending, required 0", exp_val_q.size());
      exp_val_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_acc, prev, v, nz;
    reset    = 1'b0;
    in_valid = 1'b0;
    setup(0, 0, 0);
    repeat (3) @(negedge clk);

    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    checks++; if (w_addr !== 9'd0) begin errors++; $display("FAIL reset_w_addr: got %0d, required 0", w_addr); end
    nz = 0;
    for (int n = 0; n < N_OUT; n++) if (outputData[n] !== 16'sd0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL reset_outputData: %0d nonzero, required 0", nz); end
    reset = 1'b1;
    @(negedge clk);

    // Nominal: 128*1024*8 + 512<<10 = 1572864, >>10 = 1536
    setup(1024, 8, 512); exp_next = uni(1536); send(); wait_done();

    // Negative result -1024, zeroed when ReLU is merged in
    setup(1024, -8, 0);
`ifdef DENSE_RELU_EN
    exp_next = uni(0);
`else
    exp_next = uni(-1024);
`endif
    send(); wait_done();

    // Positive saturation: raw 131072
    setup(1024, 1024, 0); exp_next = uni(32767); send(); wait_done();

    // Negative saturation: raw -131072
    setup(1024, -1024, 0);
`ifdef DENSE_RELU_EN
    exp_next = uni(0);
`else
    exp_next = uni(-32768);
`endif
    send(); wait_done();

    // Floor shift: -128 >>> 10 = -1
    setup(1, -1, 0);
`ifdef DENSE_RELU_EN
    exp_next = uni(0);
`else
    exp_next = uni(-1);
`endif
    send(); wait_done();

    // Neuron mapping: W[n][i]=n+1, bias[n]=n, inputs 1.0 -> 128*(n+1)+n
    setup(1024, 0, 0);
    wmode = 1;
    for (int n = 0; n < N_OUT; n++) begin
      biases[n] = 16'(n);
      exp_next[n*16 +: 16] = 16'(128 * (n + 1) + n);
    end
    send(); wait_done();

    // Busy/back-to-back: in_valid held high, data changes every cycle; w=8,b=0 -> out = v
    setup(0, 8, 0);
    n_acc = 0;
    prev  = -1;
    for (int n = 0; n < 1040; n++) begin
      v = 512 + 128 * (n % 5);
      for (int k = 0; k < N_IN; k++) inputData[k] = 16'(v);
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        checks++;
        if (n_acc == 0 && n != 0) begin
          errors++; $display("FAIL b2b_first_accept: got offset %0d, required 0", n);
        end else if (n_acc != 0 && n - prev != 518) begin
          errors++; $display("FAIL b2b_accept_gap: got %0d, required 518", n - prev);
        end
        prev = n;
        n_acc++;
        last_accept = cyc;
        exp_val_q.push_back(uni(v));
        exp_cyc_q.push_back(cyc + LAT);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (n_acc != 3) begin errors++; $display("FAIL b2b_accept_count: got %0d, required 3", n_acc); end
    wait_done();

    // Mid-frame reset at cycle 200 aborts the frame and clears outputs at once
    setup(1024, 8, 512); exp_next = uni(1536); send();
    while (cyc < last_accept + 200) @(negedge clk);
    reset = 1'b0;
    #1;
    nz = 0;
    for (int n = 0; n < N_OUT; n++) if (outputData[n] !== 16'sd0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL midreset_outputData: %0d nonzero, required 0", nz); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %0b, required 1", in_ready); end
    exp_val_q.delete();
    exp_cyc_q.delete();
    last_accept = -100000;
    addr_bad = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (600) @(negedge clk);
    send(); wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
